// File: rtl/fpu_ss_mem_buffer.sv
// In-order metadata FIFO ({rd, we, id}) between the FPU subsystem controller and the X-interface memory result path.
// Define FPU_SS_MEM_BUF_FALL_THROUGH_EN to let a push into an empty buffer be seen (and consumed) in the same cycle.
module fpu_ss_mem_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [4:0]                 push_rd_i,
    input  logic                       push_we_i,
    input  logic [ID_WIDTH-1:0]        push_id_i,
    input  logic                       pop_ready_i,
    output logic                       pop_valid_o,
    output logic [4:0]                 pop_rd_o,
    output logic                       pop_we_o,
    output logic [ID_WIDTH-1:0]        pop_id_o,
    input  logic [ID_WIDTH-1:0]        result_id_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_underflow_o,
    output logic                       err_id_mismatch_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]          rd;
        logic                we;
        logic [ID_WIDTH-1:0] id;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    rptr_q, wptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_uf_q, err_id_q;

    entry_t push_e, head;
    logic   empty, full, bypass;
    logic   pop_fire, push_wr, pop_rd, underflow, id_err;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CNT_W'(DEPTH));
    assign push_ready_o = !full;
    assign push_e       = '{rd: push_rd_i, we: push_we_i, id: push_id_i};

    always_comb begin
        head        = mem_q[rptr_q];
        pop_valid_o = !empty;
        bypass      = 1'b0;
        if (empty) head = '0;
`ifdef FPU_SS_MEM_BUF_FALL_THROUGH_EN
        // Empty buffer: present the incoming entry directly; if consumed now it never touches storage.
        if (empty && push_valid_i) begin
            head        = push_e;
            pop_valid_o = 1'b1;
            bypass      = pop_ready_i;
        end
`endif
    end

    assign pop_rd_o  = head.rd;
    assign pop_we_o  = head.we;
    assign pop_id_o  = head.id;

    // Flush wins over everything in its cycle, including error detection.
    assign pop_fire  = pop_ready_i & pop_valid_o & !flush_i;
    assign push_wr   = push_valid_i & push_ready_o & !flush_i & !bypass;
    assign pop_rd    = pop_fire & !bypass;
    assign underflow = pop_ready_i & !pop_valid_o & !flush_i;
    assign id_err    = pop_fire & (result_id_i != head.id);

    always_ff @(posedge clk_i) begin
        if (push_wr) mem_q[wptr_q] <= push_e;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_wr) wptr_q <= ptr_inc(wptr_q);
            if (pop_rd)  rptr_q <= ptr_inc(rptr_q);
            case ({push_wr, pop_rd})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_uf_q <= 1'b0;
            err_id_q <= 1'b0;
        end else begin
            if (underflow) err_uf_q <= 1'b1;
            if (id_err)    err_id_q <= 1'b1;
        end
    end

    assign count_o           = cnt_q;
    assign err_underflow_o   = err_uf_q;
    assign err_id_mismatch_o = err_id_q;

endmodule

// File: tb/tb_fpu_ss_mem_buffer.sv
// Scoreboard bench for fpu_ss_mem_buffer (DEPTH=4, ID_WIDTH=4): pushes queue expected heads, pops compare them.
module tb_fpu_ss_mem_buffer;

    localparam int DEPTH = 4;
    localparam int IDW   = 4;

    typedef struct packed {
        logic [4:0]     rd;
        logic           we;
        logic [IDW-1:0] id;
    } ent_t;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           push_valid_i, push_ready_o, push_we_i;
    logic [4:0]     push_rd_i;
    logic [IDW-1:0] push_id_i;
    logic           pop_ready_i, pop_valid_o, pop_we_o;
    logic [4:0]     pop_rd_o;
    logic [IDW-1:0] pop_id_o, result_id_i;
    logic           flush_i;
    logic [2:0]     count_o;
    logic           err_underflow_o, err_id_mismatch_o;

    fpu_ss_mem_buffer #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_rd_i(push_rd_i), .push_we_i(push_we_i), .push_id_i(push_id_i),
        .pop_ready_i(pop_ready_i), .pop_valid_o(pop_valid_o),
        .pop_rd_o(pop_rd_o), .pop_we_o(pop_we_o), .pop_id_o(pop_id_o),
        .result_id_i(result_id_i), .flush_i(flush_i), .count_o(count_o),
        .err_underflow_o(err_underflow_o), .err_id_mismatch_o(err_id_mismatch_o)
    );

    always #5 clk_i = ~clk_i;

    ent_t q[$];
    bit   exp_uf, exp_mm;
    int   n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic idle_inputs();
        push_valid_i = 1'b0; push_rd_i = '0; push_we_i = 1'b0; push_id_i = '0;
        pop_ready_i  = 1'b0; result_id_i = '0; flush_i = 1'b0;
    endtask

    // One clock: drive, check pre-edge outputs against the scoreboard, update it, check post-edge state.
    task automatic cycle(input logic pv, input logic [4:0] rd, input logic we, input logic [IDW-1:0] id,
                         input logic pr, input logic [IDW-1:0] rid, input logic fl);
        int   n;
        bit   ft_vis, exp_pv;
        ent_t head, ne;
        push_valid_i = pv; push_rd_i = rd; push_we_i = we; push_id_i = id;
        pop_ready_i  = pr; result_id_i = rid; flush_i = fl;
        #1;
        n      = q.size();
        ne     = '{rd: rd, we: we, id: id};
        ft_vis = 1'b0;
`ifdef FPU_SS_MEM_BUF_FALL_THROUGH_EN
        ft_vis = (n == 0) && pv;
`endif
        exp_pv = (n != 0) || ft_vis;
        head   = (n != 0) ? q[0] : (ft_vis ? ne : ent_t'('0));
        check("pop_valid", pop_valid_o, exp_pv);
        check("push_ready", push_ready_o, n != DEPTH);
        check("count_pre", count_o, n);
        check("pop_rd", pop_rd_o, head.rd);
        check("pop_we", pop_we_o, head.we);
        check("pop_id", pop_id_o, head.id);
        if (fl) q.delete();
        else begin
            if (pr && exp_pv) begin
                if (rid != head.id) exp_mm = 1'b1;
                if (n != 0) void'(q.pop_front());
            end else if (pr) exp_uf = 1'b1;
            if (pv && n != DEPTH && !(ft_vis && pr)) q.push_back(ne);
        end
        @(posedge clk_i); #1;
        idle_inputs();
        #1;
        check("count_post", count_o, q.size());
        check("err_underflow", err_underflow_o, exp_uf);
        check("err_id_mismatch", err_id_mismatch_o, exp_mm);
    endtask

    task automatic push(input logic [4:0] rd, input logic we, input logic [IDW-1:0] id);
        cycle(1'b1, rd, we, id, 1'b0, '0, 1'b0);
    endtask

    task automatic pop(input logic [IDW-1:0] rid);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, rid, 1'b0);
    endtask

    logic [IDW-1:0] nid;

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        #3;
        check("rst_count", count_o, 0);
        check("rst_pop_valid", pop_valid_o, 0);
        check("rst_push_ready", push_ready_o, 1);
        check("rst_pop_fields", {pop_rd_o, pop_we_o, pop_id_o}, 0);
        check("rst_errs", {err_underflow_o, err_id_mismatch_o}, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // single push then matching pop
        push(5'd5, 1'b1, 4'd3);
        check("tp1_valid", pop_valid_o, 1);
        check("tp1_rd", pop_rd_o, 5);
        check("tp1_we", pop_we_o, 1);
        check("tp1_id", pop_id_o, 3);
        check("tp1_count", count_o, 1);
        pop(4'd3);
        check("tp1_count0", count_o, 0);
        check("tp1_nomm", err_id_mismatch_o, 0);

        // fill, overflow drop, push+pop while full
        for (int i = 0; i < DEPTH; i++) push(5'(10 + i), 1'(i), 4'(i));
        check("full_ready", push_ready_o, 0);
        check("full_count", count_o, 4);
        push(5'd20, 1'b1, 4'd9);
        check("drop_count", count_o, 4);
        cycle(1'b1, 5'd21, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0);
        check("fullpp_count", count_o, 3);
        for (int i = 1; i < DEPTH; i++) pop(4'(i));
        check("drain_count", count_o, 0);

        // interleaved push/pop at count 2 across pointer wrap
        push(5'd1, 1'b0, 4'd5);
        push(5'd2, 1'b1, 4'd6);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 5'(k), 1'(k), 4'(7 + k), 1'b1, 4'(5 + k), 1'b0);
            check("steady_count", count_o, 2);
        end
        nid = 4'd15; pop(nid);
        nid = nid + 4'd1; pop(nid);

        // underflow, sticky
        pop(4'd0);
        check("uf_set", err_underflow_o, 1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        check("uf_sticky", err_underflow_o, 1);

        // id mismatch still consumes entry
        push(5'd1, 1'b1, 4'd7);
        pop(4'd6);
        check("mm_set", err_id_mismatch_o, 1);
        check("mm_count", count_o, 0);

        // flush with simultaneous push/pop
        for (int i = 1; i <= 3; i++) push(5'(i), 1'b1, 4'(i));
        check("fl_count_pre", count_o, 3);
        cycle(1'b1, 5'd4, 1'b1, 4'd4, 1'b1, 4'd1, 1'b1);
        check("fl_count", count_o, 0);
        check("fl_valid", pop_valid_o, 0);
        check("fl_errs", {err_underflow_o, err_id_mismatch_o}, 2'b11);

        // fall-through candidate: push+pop into empty buffer
        cycle(1'b1, 5'd9, 1'b0, 4'd2, 1'b1, 4'd2, 1'b0);
`ifdef FPU_SS_MEM_BUF_FALL_THROUGH_EN
        check("ft_count", count_o, 0);
`else
        check("ft_count", count_o, 1);
        pop(4'd2);
`endif

        // asynchronous reset mid-operation
        push(5'd3, 1'b1, 4'd10);
        push(5'd4, 1'b0, 4'd11);
        rst_i = 1'b1;
        #1;
        check("mrst_count", count_o, 0);
        check("mrst_valid", pop_valid_o, 0);
        check("mrst_errs", {err_underflow_o, err_id_mismatch_o}, 0);
        q.delete(); exp_uf = 1'b0; exp_mm = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b0;
        cycle(1'b1, 5'd6, 1'b1, 4'd12, 1'b0, '0, 1'b0);
        pop(4'd12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
